// File: rtl/deck_pkg.sv
// Shared card-shoe types and constants: card encoding, controller states, LFSR taps.
// Pure declarations; no logic, so no latency or backpressure of its own.
package deck_pkg;

    localparam int VAL_W_DEFAULT = 4;
    localparam int CARD_ACE      = 1;
    localparam int CARD_FACE     = 10;
    localparam int RANKS         = 13;

    // Galois right-shift taps for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_POLY = 16'hB400;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        SHUF
    } shoe_state_t;

    function automatic int card_init_val(input int k);
        int r;
        r = (k % RANKS) + CARD_ACE;
        return (r > CARD_FACE) ? CARD_FACE : r;
    endfunction

endpackage

// File: rtl/deck_shoe_if.sv
// Shoe bus between the game controller (master) and the shoe (slave).
// Single-cycle request pulses, one-cycle valid strobe; no backpressure on the strobe.
interface deck_shoe_if #(
    parameter int NUM_DECKS = 1,
    parameter int VAL_W     = 4
);
    localparam int DEPTH = 52 * NUM_DECKS;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    logic             shuffle_req;
    logic             draw_req;
    logic             draw_valid;
    logic [VAL_W-1:0] draw_card;
    logic [CW-1:0]    cards_left;
    logic             empty;
    logic             busy;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [VAL_W-1:0] wr_data;
    logic [AW-1:0]    rd_addr;
    logic [VAL_W-1:0] rd_data;

    modport master (
        output shuffle_req, draw_req, wr_en, wr_addr, wr_data, rd_addr,
        input  draw_valid, draw_card, cards_left, empty, busy, rd_data
    );

    modport slave (
        input  shuffle_req, draw_req, wr_en, wr_addr, wr_data, rd_addr,
        output draw_valid, draw_card, cards_left, empty, busy, rd_data
    );

endinterface

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, free-running when en is high; state is the registered value.
// One-cycle update latency; no handshake.
module lfsr16
    import deck_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = state_q;
        if (en) begin
            state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? LFSR_POLY : 16'h0000);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/deck_shoe.sv
// Card shoe: self-filling ordered shoe, in-place Fisher-Yates shuffle, one card per draw.
// Draw strobe one cycle after draw_req; requests are dropped (not queued) while busy or empty.
module deck_shoe
    import deck_pkg::*;
#(
    parameter int          NUM_DECKS = 1,
    parameter int          VAL_W     = VAL_W_DEFAULT,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    deck_shoe_if.slave bus
);

    localparam int DEPTH = 52 * NUM_DECKS;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    logic [VAL_W-1:0] mem_q [DEPTH];

    shoe_state_t      state_q,      state_d;
    logic [AW-1:0]    idx_q,        idx_d;
    logic [CW-1:0]    deal_ptr_q,   deal_ptr_d;
    logic             draw_valid_q, draw_valid_d;
    logic [VAL_W-1:0] draw_card_q,  draw_card_d;
    logic [VAL_W-1:0] rd_data_q,    rd_data_d;
    logic             busy_q,       busy_d;

    logic             fill_we;
    logic             swap_we;
    logic             dbg_we;
    logic [15:0]      lfsr_state;
    logic [AW-1:0]    j;
    logic [VAL_W-1:0] mem_i;
    logic [VAL_W-1:0] mem_j;
    logic             empty_w;
    logic             unused_lfsr;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .state (lfsr_state)
    );

    assign j           = lfsr_state[AW-1:0];
    assign unused_lfsr = ^lfsr_state[15:AW];
    assign mem_i       = mem_q[idx_q];
    assign mem_j       = mem_q[j];
    assign empty_w     = (deal_ptr_q == CW'(DEPTH));

    // idx_q is the fill address in INIT and the Fisher-Yates index i in SHUF
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        deal_ptr_d   = deal_ptr_q;
        draw_valid_d = 1'b0;
        draw_card_d  = draw_card_q;
        rd_data_d    = mem_q[bus.rd_addr];
        fill_we      = 1'b0;
        swap_we      = 1'b0;
        dbg_we       = 1'b0;

        case (state_q)
            INIT: begin
                fill_we = 1'b1;
                if (idx_q == AW'(DEPTH - 1)) begin
                    state_d    = IDLE;
                    idx_d      = '0;
                    deal_ptr_d = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            IDLE: begin
                dbg_we = bus.wr_en;
                if (bus.shuffle_req) begin
                    state_d = SHUF;
                    idx_d   = AW'(DEPTH - 1);
                end else if (bus.draw_req && !empty_w) begin
                    draw_card_d  = mem_q[deal_ptr_q[AW-1:0]];
                    draw_valid_d = 1'b1;
                    deal_ptr_d   = deal_ptr_q + 1'b1;
                end
            end
            SHUF: begin
                // Out-of-range j is rejected and retried with the next LFSR value
                if (j <= idx_q) begin
                    swap_we = 1'b1;
                    if (idx_q == AW'(1)) begin
                        state_d    = IDLE;
                        idx_d      = '0;
                        deal_ptr_d = '0;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = INIT;
                idx_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= INIT;
            idx_q        <= '0;
            deal_ptr_q   <= '0;
            draw_valid_q <= 1'b0;
            draw_card_q  <= '0;
            rd_data_q    <= '0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            deal_ptr_q   <= deal_ptr_d;
            draw_valid_q <= draw_valid_d;
            draw_card_q  <= draw_card_d;
            rd_data_q    <= rd_data_d;
            busy_q       <= busy_d;
        end
    end

    // Fill, swap and debug writes are mutually exclusive by state
    always_ff @(posedge clk) begin
        if (fill_we) begin
            mem_q[idx_q] <= VAL_W'(card_init_val(int'(idx_q)));
        end
        if (swap_we) begin
            mem_q[idx_q] <= mem_j;
            mem_q[j]     <= mem_i;
        end
        if (dbg_we) begin
            mem_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign bus.draw_valid = draw_valid_q;
    assign bus.draw_card  = draw_card_q;
    assign bus.cards_left = CW'(DEPTH) - deal_ptr_q;
    assign bus.empty      = empty_w;
    assign bus.busy       = busy_q;
    assign bus.rd_data    = rd_data_q;

endmodule

// File: tb/tb_deck_shoe.sv
// Bench for deck_shoe: one-deck and four-deck shoes, table vectors, random draws/writes vs a card-array model.
module tb_deck_shoe;

    logic clk = 1'b0;
    logic rst1;
    logic rst4;

    always #5 clk = ~clk;

    deck_shoe_if #(.NUM_DECKS(1), .VAL_W(4)) b1 ();
    deck_shoe_if #(.NUM_DECKS(4), .VAL_W(4)) b4 ();

    deck_shoe #(.NUM_DECKS(1), .VAL_W(4), .LFSR_SEED(16'hACE1)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (b1.slave)
    );

    deck_shoe #(.NUM_DECKS(4), .VAL_W(4), .LFSR_SEED(16'hACE1)) dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (b4.slave)
    );

    typedef struct {
        bit draw;
        bit exp_vld;
        int exp_card;
        int exp_left;
    } vec_t;

    vec_t vecs[14];
    int   total = 0;
    int   bad   = 0;
    int   mdl[52];
    int   ptr;
    int   lastc;
    int   shuf[52];
    int   hist[16];

    function automatic int ord(input int k);
        int r;
        r = (k % 13) + 1;
        return (r > 10) ? 10 : r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n1;
        int n4;
        int n;
        int cnt;
        int diff;

        b1.shuffle_req = 1'b0; b1.draw_req = 1'b0; b1.wr_en = 1'b0;
        b1.wr_addr = '0; b1.wr_data = '0; b1.rd_addr = '0;
        b4.shuffle_req = 1'b0; b4.draw_req = 1'b0; b4.wr_en = 1'b0;
        b4.wr_addr = '0; b4.wr_data = '0; b4.rd_addr = '0;
        rst1 = 1'b0;
        rst4 = 1'b0;
        tick();
        tick();

        chk("rst_busy",  32'(b1.busy), 1);
        chk("rst_left",  32'(b1.cards_left), 52);
        chk("rst_empty", 32'(b1.empty), 0);
        chk("rst_valid", 32'(b1.draw_valid), 0);
        chk("rst_card",  32'(b1.draw_card), 0);
        chk("rst_rd",    32'(b1.rd_data), 0);
        chk("rst_left4", 32'(b4.cards_left), 208);

        // INIT length: count edges until busy drops
        rst1 = 1'b1;
        rst4 = 1'b1;
        n1 = 0;
        n4 = 0;
        for (int c = 1; c <= 300; c++) begin
            tick();
            if (n1 == 0 && !b1.busy) n1 = c;
            if (n4 == 0 && !b4.busy) n4 = c;
        end
        chk("init_len1", 32'(n1), 52);
        chk("init_len4", 32'(n4), 208);

        // Ordered shoe: 13 back-to-back draws then one idle cycle
        for (int k = 0; k < 13; k++) begin
            vecs[k] = '{1'b1, 1'b1, (k < 9) ? k + 1 : 10, 51 - k};
        end
        vecs[13] = '{1'b0, 1'b0, 10, 39};
        for (int k = 0; k < 14; k++) begin
            b1.draw_req = vecs[k].draw;
            tick();
            b1.draw_req = 1'b0;
            chk($sformatf("vec%0d_vld", k),  32'(b1.draw_valid), 32'(vecs[k].exp_vld));
            chk($sformatf("vec%0d_card", k), 32'(b1.draw_card),  vecs[k].exp_card);
            chk($sformatf("vec%0d_left", k), 32'(b1.cards_left), vecs[k].exp_left);
        end

        // Random draws, debug writes and reads against a card-array model
        for (int k = 0; k < 52; k++) mdl[k] = ord(k);
        ptr   = 13;
        lastc = 10;
        for (int c = 0; c < 150; c++) begin
            bit d;
            bit w;
            int wa;
            int wd;
            int ra;
            int ev;
            int erd;
            d  = ($urandom_range(3) != 0);
            w  = ($urandom_range(7) == 0);
            wa = $urandom_range(51);
            wd = $urandom_range(15);
            ra = $urandom_range(51);
            b1.draw_req = d;
            b1.wr_en    = w;
            b1.wr_addr  = 6'(wa);
            b1.wr_data  = 4'(wd);
            b1.rd_addr  = 6'(ra);
            erd = mdl[ra];
            ev  = 0;
            if (d && ptr < 52) begin
                ev    = 1;
                lastc = mdl[ptr];
                ptr++;
            end
            if (w) mdl[wa] = wd;
            tick();
            chk($sformatf("rnd%0d_vld", c),   32'(b1.draw_valid), 32'(ev));
            chk($sformatf("rnd%0d_card", c),  32'(b1.draw_card),  32'(lastc));
            chk($sformatf("rnd%0d_left", c),  32'(b1.cards_left), 32'(52 - ptr));
            chk($sformatf("rnd%0d_empty", c), 32'(b1.empty),      32'(ptr == 52));
            chk($sformatf("rnd%0d_rd", c),    32'(b1.rd_data),    32'(erd));
        end
        b1.draw_req = 1'b0;

        // Restore the ordered shoe through the debug port
        for (int k = 0; k < 52; k++) begin
            b1.wr_en   = 1'b1;
            b1.wr_addr = 6'(k);
            b1.wr_data = 4'(ord(k));
            tick();
        end
        b1.wr_en = 1'b0;
        chk("pre_shuf_empty", 32'(b1.empty), 32'(ptr == 52));

        // Shuffle and draw together: draw dropped, shuffle starts
        b1.shuffle_req = 1'b1;
        b1.draw_req    = 1'b1;
        tick();
        chk("sd_valid", 32'(b1.draw_valid), 0);
        chk("sd_busy",  32'(b1.busy), 1);
        // Writes and requests while shuffling must be ignored
        b1.wr_en   = 1'b1;
        b1.wr_addr = 6'd0;
        b1.wr_data = 4'd15;
        tick();
        tick();
        tick();
        chk("shuf_no_valid", 32'(b1.draw_valid), 0);
        b1.wr_en       = 1'b0;
        b1.shuffle_req = 1'b0;
        b1.draw_req    = 1'b0;
        n = 3;
        while (b1.busy && n < 5000) begin
            tick();
            n++;
        end
        chk("shuf_timeout", 32'(b1.busy), 0);
        chk("shuf_minlen",  32'(n >= 51), 1);
        chk("shuf_left",    32'(b1.cards_left), 52);
        chk("shuf_empty",   32'(b1.empty), 0);

        for (int k = 0; k < 52; k++) begin
            b1.rd_addr = 6'(k);
            tick();
            shuf[k] = int'(b1.rd_data);
        end
        foreach (hist[v]) hist[v] = 0;
        diff = 0;
        for (int k = 0; k < 52; k++) begin
            hist[shuf[k]]++;
            if (shuf[k] != ord(k)) diff++;
        end
        for (int v = 1; v <= 10; v++) begin
            chk($sformatf("hist1_%0d", v), 32'(hist[v]), (v == 10) ? 16 : 4);
        end
        chk("hist1_other", 32'(hist[0] + hist[11] + hist[12] + hist[13] + hist[14] + hist[15]), 0);
        chk("shuf_reordered", 32'(diff > 0), 1);

        // Deal the whole shuffled shoe, then one extra request
        cnt = 0;
        for (int k = 0; k < 52; k++) begin
            b1.draw_req = 1'b1;
            tick();
            if (b1.draw_valid) cnt++;
            chk($sformatf("deal%0d_card", k), 32'(b1.draw_card), 32'(shuf[k]));
        end
        b1.draw_req = 1'b0;
        chk("deal_count", 32'(cnt), 52);
        chk("deal_empty", 32'(b1.empty), 1);
        chk("deal_left",  32'(b1.cards_left), 0);
        b1.draw_req = 1'b1;
        tick();
        b1.draw_req = 1'b0;
        chk("extra_valid", 32'(b1.draw_valid), 0);
        chk("extra_empty", 32'(b1.empty), 1);

        // Reset in the middle of a shuffle
        b1.shuffle_req = 1'b1;
        tick();
        b1.shuffle_req = 1'b0;
        for (int c = 0; c < 30; c++) tick();
        chk("mid_busy_pre", 32'(b1.busy), 1);
        chk("mid_left_pre", 32'(b1.cards_left), 0);
        rst1 = 1'b0;
        #2;
        chk("mid_rst_busy",  32'(b1.busy), 1);
        chk("mid_rst_left",  32'(b1.cards_left), 52);
        chk("mid_rst_valid", 32'(b1.draw_valid), 0);
        tick();
        rst1 = 1'b1;
        n = 0;
        while (b1.busy && n < 200) begin
            tick();
            n++;
        end
        chk("mid_init_len", 32'(n), 52);
        for (int k = 0; k < 3; k++) begin
            b1.draw_req = 1'b1;
            tick();
            chk($sformatf("mid_draw%0d_vld", k),  32'(b1.draw_valid), 1);
            chk($sformatf("mid_draw%0d_card", k), 32'(b1.draw_card),  32'(k + 1));
        end
        b1.draw_req = 1'b0;

        // Four-deck shuffle histogram
        b4.shuffle_req = 1'b1;
        tick();
        b4.shuffle_req = 1'b0;
        chk("shuf4_busy", 32'(b4.busy), 1);
        n = 0;
        while (b4.busy && n < 20000) begin
            tick();
            n++;
        end
        chk("shuf4_timeout", 32'(b4.busy), 0);
        chk("shuf4_left",    32'(b4.cards_left), 208);
        foreach (hist[v]) hist[v] = 0;
        for (int k = 0; k < 208; k++) begin
            b4.rd_addr = 8'(k);
            tick();
            hist[int'(b4.rd_data)]++;
        end
        for (int v = 1; v <= 10; v++) begin
            chk($sformatf("hist4_%0d", v), 32'(hist[v]), (v == 10) ? 64 : 16);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
